hcpu_multicycle: RTL and testbench
==================================

// Module: hcpu_multicycle
// PURPOSE
//  Parametrised multi-cycle Hack-ISA CPU core, the successor to the single-cycle hCPU.
//  Uses a fetch/execute state machine.
//  Talks to instruction and data memories through valid/ready handshakes, so wait-state RAM/ROM and MMIO can stall it.
//  Adds a read-modify-write data path, halt detection and a retired-instruction counter.
//  Sits between the instruction ROM, the data RAM/MMIO decoder and the top-level computer.
// PARAMETERS
//  WIDTH    16  data/instruction width; A-instr immediate = instruction[WIDTH-2:0], zero-extended
//  PC_W     15  program counter width; pc wraps modulo 2**PC_W
//  COUNT_W  32  width of the retired-instruction counter
// PORTS
//  clock        in   1        single clock, rising edge
//  reset_n      in   1        asynchronous, active-low reset
//  instr_req    out  1        fetch request; pc valid while high
//  pc           out  PC_W     address of instruction being fetched
//  instr_valid  in   1        instruction present this cycle (accepted while instr_req=1)
//  instruction  in   WIDTH    Hack instruction word
//  readM        out  1        data read request
//  writeM       out  1        data write request
//  addressM     out  WIDTH    data address (= A register at issue)
//  outM         out  WIDTH    write data
//  inM          in   WIDTH    read data, sampled when readM & mem_ready
//  mem_ready    in   1        data access completes this cycle
//  halted       out  1        CPU stopped at a jump-to-self loop
//  retired      out  COUNT_W  instructions committed since reset; wraps
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - State=IDLE; A, D, IR, MDR, pc and retired all 0.
//   - instr_req, readM, writeM and halted are 0 immediately, even mid-access.
//  States and transitions:
//   - IDLE: one cycle after reset release, then FETCH.
//   - FETCH: instr_req=1. On instr_valid, latch IR and go to EXEC; otherwise hold. pc stays stable.
//   - EXEC, A-instr: A<=imm, pc<=pc+1, commit, go to FETCH.
//   - EXEC, C-instr with a=1: go to MEM_RD.
//   - EXEC, C-instr with a=0 and dest[0]=1: go to MEM_WR.
//   - EXEC, otherwise: commit, go to FETCH.
//   - MEM_RD: readM=1, addressM=A. On mem_ready, MDR<=inM. Then MEM_WR if dest[0], else commit and go to FETCH.
//   - MEM_WR: writeM=1, addressM=A, outM=ALU result (using MDR if a=1). Hold all outputs until mem_ready, then commit and go to FETCH.
//   - HALT: all requests 0, halted=1. Stays until reset.
//  Commit (one edge):
//   - D<=alu if dest[1]; A<=alu if dest[2].
//   - Memory address is always the pre-commit A (AMD=... writes old A).
//   - Jump when (j[2]&ng) | (j[1]&zr) | (j[0]&~ng&~zr): pc<=A_old[PC_W-1:0]; else pc<=pc+1.
//   - retired<=retired+1.
//   - Taken jump with A_old==pc is a halt: go to HALT instead of FETCH.
//  Other rules:
//   - ALU follows Hack comp encoding (zx,nx,zy,ny,f,no); add wraps at WIDTH; zr/ng from the WIDTH-bit result.
//   - readM and writeM are never high together. Request outputs come from registered state (no combinational path from inputs to outputs).
//  Latency with zero-wait memory (FETCH cycle included):
//   - A-instr and register-only C-instr: 2 cycles.
//   - Memory read or memory write: 3 cycles.
//   - Read-modify-write: 4 cycles.
//   - Each mem_ready=0 cycle adds one.
//  instr_valid while not in FETCH is ignored.
// TESTING
//  1. @5; D=A; @7; D=D+A; @0; M=D, zero-wait -> RAM[0]=12, retired=6, writeM pulses once with addressM=0.
//  2. RAM[3]=9; @3; M=M+1 with mem_ready low 2 cycles per access -> readM held 3 cycles, then writeM held 3 cycles; RAM[3]=10.
//  3. D=-1; @20; D;JLT -> pc=20. Then D=0; @30; D;JGT -> pc falls through. @40; 0;JMP -> pc=40.
//  4. At pc=8: @8; 0;JMP -> halted=1 within 2 cycles of that instr's commit; instr_req stays 0; retired frozen.
//  5. Assert reset_n=0 mid-MEM_WR (writeM=1) -> writeM=0 with no clock edge; after release: IDLE 1 cycle, then FETCH at pc=0.
//  6. WIDTH=32, PC_W=20: run #1 and a pc wrap test (jump to 2**20-1, then non-jump) -> same results, pc=0.

Source files
------------

// File: rtl/hcpu_multicycle.sv
// +--------------------------------------------------------------------------+
// | hcpu_multicycle                                                          |
// | Multi-cycle Hack-ISA CPU with handshaked instruction/data memory ports.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module hcpu_multicycle #(
    parameter int WIDTH   = 16,
    parameter int PC_W    = 15,
    parameter int COUNT_W = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               instr_req,
    output logic [PC_W-1:0]    pc,
    input  logic               instr_valid,
    input  logic [WIDTH-1:0]   instruction,
    output logic               readM,
    output logic               writeM,
    output logic [WIDTH-1:0]   addressM,
    output logic [WIDTH-1:0]   outM,
    input  logic [WIDTH-1:0]   inM,
    input  logic               mem_ready,
    output logic               halted,
    output logic [COUNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM_RD = 3'd3;
    localparam logic [2:0] S_MEM_WR = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0]         state_q,   state_d;
    logic [WIDTH-1:0]   areg_q,    areg_d;
    logic [WIDTH-1:0]   dreg_q,    dreg_d;
    logic [WIDTH-1:0]   ir_q,      ir_d;
    logic [WIDTH-1:0]   mdr_q,     mdr_d;
    logic [PC_W-1:0]    pc_q,      pc_d;
    logic [COUNT_W-1:0] retired_q, retired_d;

    logic               is_c;
    logic               a_bit;
    logic [5:0]         comp;
    logic [2:0]         dest;
    logic [2:0]         jmp;
    logic [WIDTH-1:0]   y_wr;
    logic [WIDTH-1:0]   y_cm;
    logic [WIDTH-1:0]   alu_wr;
    logic [WIDTH-1:0]   alu_cm;
    logic               zr;
    logic               ng;
    logic               take;
    logic               self_loop;
    logic               commit;

    function automatic logic [WIDTH-1:0] alu(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic [5:0]       c);
        logic [WIDTH-1:0] xx;
        logic [WIDTH-1:0] yy;
        logic [WIDTH-1:0] r;
        xx = c[5] ? '0 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? '0 : y;
        if (c[2]) yy = ~yy;
        r = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) r = ~r;
        return r;
    endfunction

    assign is_c  = ir_q[WIDTH-1];
    assign a_bit = ir_q[12];
    assign comp  = ir_q[11:6];
    assign dest  = ir_q[5:3];
    assign jmp   = ir_q[2:0];

    // Write data only ever sees registered operands; the commit path may
    // additionally bypass inM so a read can retire in its own access cycle.
    assign y_wr   = a_bit ? mdr_q : areg_q;
    assign y_cm   = (state_q == S_MEM_RD) ? inM : y_wr;
    assign alu_wr = alu(dreg_q, y_wr, comp);
    assign alu_cm = alu(dreg_q, y_cm, comp);

    assign zr        = (alu_cm == '0);
    assign ng        = alu_cm[WIDTH-1];
    assign take      = (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
    assign self_loop = (areg_q == WIDTH'(pc_q));

    always_comb begin
        state_d   = state_q;
        areg_d    = areg_q;
        dreg_d    = dreg_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        commit    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instruction;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!is_c) begin
                    areg_d    = {1'b0, ir_q[WIDTH-2:0]};
                    pc_d      = pc_q + PC_W'(1);
                    retired_d = retired_q + COUNT_W'(1);
                    state_d   = S_FETCH;
                end else if (a_bit) begin
                    state_d = S_MEM_RD;
                end else if (dest[0]) begin
                    state_d = S_MEM_WR;
                end else begin
                    commit = 1'b1;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    mdr_d = inM;
                    if (dest[0]) state_d = S_MEM_WR;
                    else         commit  = 1'b1;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) commit = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Jump target and halt test use A as it was before this commit.
        if (commit) begin
            if (dest[1]) dreg_d = alu_cm;
            if (dest[2]) areg_d = alu_cm;
            retired_d = retired_q + COUNT_W'(1);
            if (take) begin
                pc_d    = areg_q[PC_W-1:0];
                state_d = self_loop ? S_HALT : S_FETCH;
            end else begin
                pc_d    = pc_q + PC_W'(1);
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            areg_q    <= '0;
            dreg_q    <= '0;
            ir_q      <= '0;
            mdr_q     <= '0;
            pc_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            areg_q    <= areg_d;
            dreg_q    <= dreg_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    assign instr_req = (state_q == S_FETCH);
    assign readM     = (state_q == S_MEM_RD);
    assign writeM    = (state_q == S_MEM_WR);
    assign halted    = (state_q == S_HALT);
    assign addressM  = areg_q;
    assign outM      = alu_wr;
    assign pc        = pc_q;
    assign retired   = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_hcpu_multicycle.sv
// +--------------------------------------------------------------------------+
// | tb_hcpu_multicycle                                                       |
// | Scoreboard bench: wait-state ROM/RAM models for 16- and 32-bit cores.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_hcpu_multicycle;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n = 1'b0;
    logic        instr_req, instr_valid = 1'b0;
    logic [14:0] pc;
    logic [15:0] instruction = '0;
    logic        readM, writeM, mem_ready = 1'b0, halted;
    logic [15:0] addressM, outM, inM = '0;
    logic [31:0] retired;

    logic        rst_n_w = 1'b0;
    logic        ireq_w, iv_w = 1'b0;
    logic [19:0] pc_w;
    logic [31:0] ins_w = '0;
    logic        rdM_w, wrM_w, mr_w = 1'b0, halted_w;
    logic [31:0] addrM_w, outM_w, inM_w = '0;
    logic [31:0] retired_w;

    hcpu_multicycle dut (
        .clock(clock), .reset_n(reset_n), .instr_req(instr_req), .pc(pc),
        .instr_valid(instr_valid), .instruction(instruction), .readM(readM),
        .writeM(writeM), .addressM(addressM), .outM(outM), .inM(inM),
        .mem_ready(mem_ready), .halted(halted), .retired(retired)
    );

    hcpu_multicycle #(.WIDTH(32), .PC_W(20), .COUNT_W(32)) dut_w (
        .clock(clock), .reset_n(rst_n_w), .instr_req(ireq_w), .pc(pc_w),
        .instr_valid(iv_w), .instruction(ins_w), .readM(rdM_w),
        .writeM(wrM_w), .addressM(addrM_w), .outM(outM_w), .inM(inM_w),
        .mem_ready(mr_w), .halted(halted_w), .retired(retired_w)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] cins(input logic a, input logic [5:0] c,
                                         input logic [2:0] d, input logic [2:0] j);
        return {3'b111, a, c, d, j};
    endfunction

    // 16-bit memory models
    logic [15:0] rom [0:63];
    logic [15:0] ram [0:15];
    logic [14:0] fq[$];
    wr_t         wq[$];
    int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
    int rd_cyc = 0, wr_cyc = 0, n_ovl = 0, n_wr = 0;
    bit noise = 1'b0, trk = 1'b0;

    always @(negedge clock) begin
        if (!reset_n) begin
            instr_valid = 1'b0;
            mem_ready   = 1'b0;
            icnt        = 0;
            dcnt        = 0;
        end else begin
            if (instr_req) begin
                if (instr_valid) icnt = 0;
                if (icnt >= iwait) begin
                    instr_valid = 1'b1;
                    instruction = rom[pc[5:0]];
                    if (trk) begin
                        chk_eq("fetch_q", fq.size() != 0, 1);
                        if (fq.size() != 0) chk_eq("fetch_pc", pc, fq.pop_front());
                    end
                end else begin
                    instr_valid = 1'b0;
                    icnt++;
                end
            end else begin
                icnt        = 0;
                instr_valid = noise ? 1'($urandom) : 1'b0;
                instruction = noise ? 16'($urandom) : 16'h0;
            end

            if (readM && writeM) n_ovl++;
            if (readM)  rd_cyc++;
            if (writeM) wr_cyc++;
            if (readM || writeM) begin
                if (mem_ready) dcnt = 0;
                if (dcnt >= dwait) begin
                    mem_ready = 1'b1;
                end else begin
                    mem_ready = 1'b0;
                    dcnt++;
                end
                if (readM) inM = ram[addressM[3:0]];
                if (mem_ready && writeM) begin
                    n_wr++;
                    chk_eq("wr_q", wq.size() != 0, 1);
                    if (wq.size() != 0) begin
                        wr_t e;
                        e = wq.pop_front();
                        chk_eq("wr_addr", addressM, e.a);
                        chk_eq("wr_data", outM, e.d);
                    end
                    ram[addressM[3:0]] = outM;
                end
            end else begin
                mem_ready = 1'b0;
                dcnt      = 0;
                inM       = noise ? 16'($urandom) : 16'h0;
            end
        end
    end

    // 32-bit zero-wait models; pc 0xFFFFF holds a no-op so the pc wraps.
    logic [31:0] rom_w [0:15];
    logic [31:0] ram_w [0:15];
    logic [19:0] fq_w[$];
    wr_t         wq_w[$];
    bit          done_w = 1'b0;
    logic [31:0] ret_w = '0;

    always @(negedge clock) begin
        if (!rst_n_w) begin
            iv_w = 1'b0;
            mr_w = 1'b0;
        end else begin
            iv_w = ireq_w;
            if (ireq_w) begin
                ins_w = (pc_w == 20'hFFFFF) ? 32'h8000_0A80 : rom_w[pc_w[3:0]];
                if (!done_w) begin
                    chk_eq("fetch32_q", fq_w.size() != 0, 1);
                    if (fq_w.size() != 0) begin
                        chk_eq("fetch32_pc", pc_w, fq_w.pop_front());
                        if (fq_w.size() == 0) begin
                            done_w = 1'b1;
                            ret_w  = retired_w;
                        end
                    end
                end
            end
            mr_w = rdM_w | wrM_w;
            if (rdM_w) inM_w = ram_w[addrM_w[3:0]];
            if (wrM_w && !done_w) begin
                chk_eq("wr32_q", wq_w.size() != 0, 1);
                if (wq_w.size() != 0) begin
                    wr_t e;
                    e = wq_w.pop_front();
                    chk_eq("wr32_addr", addrM_w, e.a);
                    chk_eq("wr32_data", outM_w, e.d);
                end
                ram_w[addrM_w[3:0]] = outM_w;
            end
        end
    end

    task automatic reset16();
        @(negedge clock);
        reset_n = 1'b0;
        fq.delete();
        wq.delete();
        foreach (rom[i]) rom[i] = '0;
        foreach (ram[i]) ram[i] = '0;
        rd_cyc = 0;
        wr_cyc = 0;
        n_wr   = 0;
        repeat (2) @(negedge clock);
    endtask

    task automatic release16();
        reset_n = 1'b1;
    endtask

    task automatic wait_halt(input int budget, output int n);
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk_eq("halt_seen", halted, 1);
    endtask

    initial begin
        int n;
        wr_t e;

        // Reset state
        #2;
        chk_eq("rst_instr_req", instr_req, 0);
        chk_eq("rst_readM", readM, 0);
        chk_eq("rst_writeM", writeM, 0);
        chk_eq("rst_halted", halted, 0);
        chk_eq("rst_pc", pc, 0);
        chk_eq("rst_retired", retired, 0);

        // Program 1: RAM[0] = 5 + 7, then halt at pc 8
        reset16();
        rom[0] = 16'd5;
        rom[1] = cins(0, 6'b110000, 3'b010, 3'b000);
        rom[2] = 16'd7;
        rom[3] = cins(0, 6'b000010, 3'b010, 3'b000);
        rom[4] = 16'd0;
        rom[5] = cins(0, 6'b001100, 3'b001, 3'b000);
        rom[6] = cins(0, 6'b101010, 3'b000, 3'b000);
        rom[7] = 16'd8;
        rom[8] = cins(0, 6'b101010, 3'b000, 3'b111);
        for (int i = 0; i <= 8; i++) fq.push_back(15'(i));
        e.a = 32'd0; e.d = 32'd12; wq.push_back(e);
        trk = 1'b1;
        release16();
        wait_halt(60, n);
        chk_eq("p1_latency", n, 20);
        chk_eq("p1_ram0", ram[0], 12);
        chk_eq("p1_n_wr", n_wr, 1);
        chk_eq("p1_halt_pc", pc, 8);
        chk_eq("p1_retired", retired, 9);
        repeat (5) @(negedge clock);
        chk_eq("halt_instr_req", instr_req, 0);
        chk_eq("halt_held", halted, 1);
        chk_eq("halt_retired", retired, 9);
        chk_eq("p1_fq_left", fq.size(), 0);
        chk_eq("p1_wq_left", wq.size(), 0);

        // Program 2: RMW M=M+1 at RAM[3] with two wait states per access
        reset16();
        ram[3] = 16'd9;
        dwait  = 2;
        rom[0] = 16'd3;
        rom[1] = cins(1, 6'b110111, 3'b001, 3'b000);
        rom[2] = 16'd3;
        rom[3] = cins(0, 6'b101010, 3'b000, 3'b111);
        for (int i = 0; i <= 3; i++) fq.push_back(15'(i));
        e.a = 32'd3; e.d = 32'd10; wq.push_back(e);
        release16();
        wait_halt(100, n);
        chk_eq("p2_rd_cycles", rd_cyc, 3);
        chk_eq("p2_wr_cycles", wr_cyc, 3);
        chk_eq("p2_ram3", ram[3], 10);
        chk_eq("p2_retired", retired, 4);
        chk_eq("p2_wq_left", wq.size(), 0);
        dwait = 0;

        // Program 3: conditional jumps, with bus noise outside handshakes
        reset16();
        noise   = 1'b1;
        rom[0]  = cins(0, 6'b111010, 3'b010, 3'b000);
        rom[1]  = 16'd20;
        rom[2]  = cins(0, 6'b001100, 3'b000, 3'b100);
        rom[20] = cins(0, 6'b101010, 3'b010, 3'b000);
        rom[21] = 16'd30;
        rom[22] = cins(0, 6'b001100, 3'b000, 3'b001);
        rom[23] = 16'd40;
        rom[24] = cins(0, 6'b101010, 3'b000, 3'b111);
        rom[40] = 16'd41;
        rom[41] = cins(0, 6'b101010, 3'b000, 3'b111);
        foreach (rom[i]) if (i inside {0, 1, 2, 20, 21, 22, 23, 24, 40, 41}) fq.push_back(15'(i));
        release16();
        wait_halt(80, n);
        chk_eq("p3_halt_pc", pc, 41);
        chk_eq("p3_retired", retired, 10);
        chk_eq("p3_fq_left", fq.size(), 0);
        chk_eq("p3_n_wr", n_wr, 0);
        noise = 1'b0;

        // Program 4: asynchronous reset while a write is stalled
        reset16();
        dwait  = 30;
        rom[0] = 16'd5;
        rom[1] = cins(0, 6'b111111, 3'b001, 3'b000);
        fq.push_back(15'd0);
        fq.push_back(15'd1);
        release16();
        n = 0;
        while (!writeM && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk_eq("p4_wr_req_seen", writeM, 1);
        repeat (2) @(negedge clock);
        chk_eq("p4_wr_held", writeM, 1);
        #2 reset_n = 1'b0;
        #1;
        chk_eq("arst_writeM", writeM, 0);
        chk_eq("arst_readM", readM, 0);
        chk_eq("arst_instr_req", instr_req, 0);
        chk_eq("arst_pc", pc, 0);
        chk_eq("arst_retired", retired, 0);
        chk_eq("p4_fq_left", fq.size(), 0);
        trk   = 1'b0;
        dwait = 0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk_eq("idle_instr_req", instr_req, 0);
        @(negedge clock);
        chk_eq("fetch_instr_req", instr_req, 1);
        chk_eq("fetch_pc0", pc, 0);
        @(negedge clock);
        reset_n = 1'b0;

        // Wide core: program 1 followed by a jump to the top of pc space
        foreach (rom_w[i]) rom_w[i] = '0;
        foreach (ram_w[i]) ram_w[i] = '0;
        rom_w[0] = 32'd5;
        rom_w[1] = 32'h8000_0000 | 32'(cins(0, 6'b110000, 3'b010, 3'b000) & 16'h1FFF);
        rom_w[2] = 32'd7;
        rom_w[3] = 32'h8000_0000 | 32'(cins(0, 6'b000010, 3'b010, 3'b000) & 16'h1FFF);
        rom_w[4] = 32'd0;
        rom_w[5] = 32'h8000_0000 | 32'(cins(0, 6'b001100, 3'b001, 3'b000) & 16'h1FFF);
        rom_w[6] = 32'h000F_FFFF;
        rom_w[7] = 32'h8000_0A87;
        for (int i = 0; i <= 7; i++) fq_w.push_back(20'(i));
        fq_w.push_back(20'hFFFFF);
        fq_w.push_back(20'h0);
        e.a = 32'd0; e.d = 32'd12; wq_w.push_back(e);
        @(negedge clock);
        rst_n_w = 1'b1;
        n = 0;
        while (!done_w && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk_eq("w_done", done_w, 1);
        chk_eq("w_retired_at_wrap", ret_w, 9);
        chk_eq("w_ram0", ram_w[0], 12);
        chk_eq("w_wq_left", wq_w.size(), 0);
        rst_n_w = 1'b0;

        chk_eq("rd_wr_overlap", n_ovl, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
